stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N:1 stream multiplexer; successor to the fixed 4:1 2-bit combinational mux.
//  Round-robin arbitration selects one requesting valid/ready input per cycle into a registered output stage.
//  Reports the source index of each beat. Sits between parallel producers and a single shared consumer.
// PARAMETERS
//  DATA_W  8  width of each input and output data beat (>=1)
//  NUM_IN  4  number of input channels (>=2; need not be a power of two)
//  SEL_W   $clog2(NUM_IN)  localparam; width of channel index
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              synchronous active-low reset
//  in_valid   in   NUM_IN         per-channel beat valid
//  in_data    in   NUM_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
//  in_ready   out  NUM_IN         per-channel accept; one-hot or zero
//  out_valid  out  1              output beat valid
//  out_data   out  DATA_W         output beat
//  out_sel    out  SEL_W          index of the channel that sourced out_data
//  out_ready  in   1              consumer accept
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0; in_ready=0 while rst_n=0.
//  Reset mid-transfer: held beat is dropped; no channel is considered accepted during reset.
//  load = !out_valid || out_ready (output register empty or draining this cycle).
//  Arbitration: search in_valid from rr_ptr upward, wrapping NUM_IN-1 -> 0; first set bit is granted.
//  in_ready[g] = load && in_valid[g] for granted g only; all other in_ready bits are 0.
//  Transfer on channel g when in_valid[g] && in_ready[g]; next cycle out_valid=1,
//  out_data=in_data[g], out_sel=g, rr_ptr = (g==NUM_IN-1) ? 0 : g+1.
//  No request while load=1: out_valid <= 0 next cycle; rr_ptr unchanged.
//  load=0 (out_valid && !out_ready): output register, out_sel and rr_ptr hold; in_ready=0.
//  Latency: 1 cycle input->output. Throughput: 1 beat/cycle with out_ready held high.
//  Fairness: each continuously requesting channel is granted within NUM_IN grants.
//  in_ready is combinational from in_valid, out_valid, out_ready and rr_ptr; it must not depend on in_data.
//  No combinational path from in_valid/in_data to out_valid/out_data.
//  Producers must hold in_valid/in_data until accepted; the block need not detect violations.
// CONFIGURATION
//  STREAM_MUX_FORCE_SEL_EN defined: adds ports force_en (in,1) and force_sel (in,SEL_W).
//   force_en=1 masks every request except in_valid[force_sel]; rr_ptr is not updated on forced grants.
//   force_sel >= NUM_IN with force_en=1 grants nothing.
//  STREAM_MUX_FORCE_SEL_EN undefined: ports absent; pure round-robin as above.
// STRUCTURE
//  Package stream_mux_pkg: function clog2_min1 (returns >=1); typedef of the channel-index type used by the arbiter.
//  Sub-module rr_arbiter #(NUM_IN): inputs req, ptr; outputs one-hot gnt, gnt_idx, any_gnt. Combinational.
//  Top: request masking (optional force), arbiter instance, rr_ptr register, output register.
// TESTING
//  1 Reset: assert rst_n=0 for 2 cycles with in_valid=4'hF -> out_valid=0, out_data=0, out_sel=0, in_ready=0.
//  2 All valid, out_ready=1, data ch i = 8'hA0+i -> out_sel 0,1,2,3,0... each cycle, out_data A0,A1,A2,A3,A0.
//  3 Only ch2 valid (8'h5C), out_ready=0 -> one beat accepted, then in_ready=0;
//    out_data=5C held until out_ready=1, then next beat.
//  4 NUM_IN=3, rr_ptr=2, in_valid=3'b011 -> ch0 granted (wrap), rr_ptr->1.
//  5 Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0; after release, ch0 has priority.
//  6 STREAM_MUX_FORCE_SEL_EN, force_en=1, force_sel=3, in_valid=4'hF -> only ch3 granted every cycle, rr_ptr unchanged.

Source files
------------

// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_pkg (package)
// Description : Shared types and helpers for the round-robin stream mux.
//               clog2_min1 returns a channel-index width of at least one bit.
//               chan_idx_t is a wide index type the arbiter uses for
//               wrap-around arithmetic before narrowing to SEL_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    localparam int IDX_MAX_W = 16;

    typedef logic [IDX_MAX_W-1:0] chan_idx_t;

    // Index width for n channels; never returns less than 1 so a
    // degenerate configuration still gets a legal vector width.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : stream_mux_pkg
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches req starting at
//               ptr and moving upward, wrapping from NUM_IN-1 back to 0; the
//               first set bit wins.
// Ports       : req      in   NUM_IN  request vector
//               ptr      in   SEL_W   highest-priority channel this cycle
//               gnt      out  NUM_IN  one-hot grant (zero when no request)
//               gnt_idx  out  SEL_W   index of the granted channel
//               any_gnt  out  1       a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any_gnt
);

    localparam chan_idx_t N_IDX = chan_idx_t'(NUM_IN);

    chan_idx_t cand;

    // Candidate index is computed in a wide type so ptr+k never overflows
    // before the single conditional subtract folds it back into range.
    // ptr is always < NUM_IN, so one subtract is enough even when NUM_IN
    // is not a power of two.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = chan_idx_t'(ptr) + chan_idx_t'(k);
            if (cand >= N_IDX) begin
                cand = cand - N_IDX;
            end
            if (!any_gnt && req[cand[SEL_W-1:0]]) begin
                gnt[cand[SEL_W-1:0]] = 1'b1;
                gnt_idx              = cand[SEL_W-1:0];
                any_gnt              = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : Parametrised N:1 valid/ready stream multiplexer with
//               round-robin arbitration and a registered output stage.
//               Reports the source channel of every output beat.
//               Optional feature macro: STREAM_MUX_FORCE_SEL_EN adds
//               force_en/force_sel to lock arbitration onto one channel.
// Ports       : clk        in   1              rising-edge clock
//               rst_n      in   1              synchronous active-low reset
//               in_valid   in   NUM_IN         per-channel beat valid
//               in_data    in   NUM_IN*DATA_W  channel i at [i*DATA_W +: DATA_W]
//               in_ready   out  NUM_IN         per-channel accept, one-hot/zero
//               out_valid  out  1              output beat valid
//               out_data   out  DATA_W         output beat
//               out_sel    out  SEL_W          source channel of out_data
//               out_ready  in   1              consumer accept
//               force_en   in   1              (macro only) restrict grants
//               force_sel  in   SEL_W          (macro only) forced channel
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
`ifdef STREAM_MUX_FORCE_SEL_EN
    input  logic                     force_en,
    input  logic [SEL_W-1:0]         force_sel,
`endif
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  rr_ptr;
    logic              load;
    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any_gnt;
    logic              ptr_adv;
    logic [DATA_W-1:0] gnt_data;

    // Output register can take a new beat when empty or draining now.
    assign load = !out_valid || out_ready;

`ifdef STREAM_MUX_FORCE_SEL_EN
    // A force_sel outside 0..NUM_IN-1 matches no channel, so nothing is
    // granted in that case.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_req_mask
        assign req[i] = in_valid[i] && (!force_en || (force_sel == SEL_W'(i)));
    end
    // Forced grants leave the fairness pointer where it was.
    assign ptr_adv = !force_en;
`else
    assign req     = in_valid;
    assign ptr_adv = 1'b1;
`endif

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // in_ready depends only on in_valid, the output stage state and rr_ptr.
    // It is forced low during reset so no producer sees an acceptance there.
    assign in_ready = (rst_n && load) ? gnt : '0;

    // One-hot AND-OR select keeps the data path free of wide index math.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) begin
                gnt_data = gnt_data | in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (any_gnt) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_sel   <= gnt_idx;
                if (ptr_adv) begin
                    rr_ptr <= (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0
                                                              : gnt_idx + SEL_W'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : stream_mux_rr
`default_nettype wire
